// File: rtl/fft_stage_ctrl.sv
// Control sequencer for a pipelined radix-2 DIF FFT: frames the input stream,
// delays the sample position along the stage chain and derives per-stage sw/twiddle.
module fft_stage_ctrl #(
  parameter int LOG2N      = 3,
  parameter int PE_LATENCY = 2,
  parameter int FCNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         in_sof,
  output logic [LOG2N-1:0]             sw,
  output logic [LOG2N*(LOG2N-1)-1:0]   tw_addr,
  output logic                         out_valid,
  output logic                         out_sof,
  output logic                         out_eof,
  output logic                         busy,
  output logic                         sync_err,
  output logic [FCNT_W-1:0]            frame_cnt
);

  localparam int DEPTH = LOG2N*PE_LATENCY + 1;
  localparam int LAST  = DEPTH - 1;
  localparam int TW_W  = LOG2N - 1;
  localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'((1 << LOG2N) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [LOG2N-1:0]        cnt_q, cnt_d;
  logic                    sync_err_q, sync_err_d;
  logic [FCNT_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic [LOG2N-1:0]        sw_q, sw_d;
  logic [LOG2N*TW_W-1:0]   tw_q, tw_d;

  logic                    acc_valid;
  logic                    acc_sof;
  logic [LOG2N-1:0]        acc_idx;

  logic [DEPTH-1:0]        tap_valid_q, tap_valid_d;
  logic [DEPTH-1:0]        tap_sof_q, tap_sof_d;
  logic [LOG2N-1:0]        tap_idx_q [DEPTH];
  logic [LOG2N-1:0]        tap_idx_d [DEPTH];

  // Input framing: an sof always restarts a frame; a non-sof sample outside a frame is dropped.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
    acc_valid  = 1'b0;
    acc_sof    = 1'b0;
    acc_idx    = '0;
    if (in_valid) begin
      case (state_q)
        IDLE: begin
          if (in_sof) begin
            acc_valid = 1'b1;
            acc_sof   = 1'b1;
            cnt_d     = LOG2N'(1);
            state_d   = RUN;
          end else begin
            sync_err_d = 1'b1;
          end
        end
        RUN: begin
          acc_valid = 1'b1;
          if (in_sof) begin
            sync_err_d = 1'b1;
            acc_sof    = 1'b1;
            cnt_d      = LOG2N'(1);
          end else begin
            acc_idx = cnt_q;
            if (cnt_q == IDX_LAST) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + LOG2N'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    tap_valid_d = {tap_valid_q[DEPTH-2:0], acc_valid};
    tap_sof_d   = {tap_sof_q[DEPTH-2:0], acc_sof};
    tap_idx_d[0] = acc_idx;
    for (int t = 1; t < DEPTH; t++) begin
      tap_idx_d[t] = tap_idx_q[t-1];
    end
  end

  // Each stage looks at the tap where its samples arrive and holds its controls across gaps.
  genvar gi;
  generate
    for (gi = 0; gi < LOG2N; gi++) begin : g_stage
      localparam int T = gi*PE_LATENCY;
      localparam int M = LOG2N - 1 - gi;
      localparam logic [LOG2N-1:0] K_MASK = LOG2N'((1 << M) - 1);

      logic             stage_sw;
      logic [LOG2N-1:0] stage_k;

      assign stage_sw = tap_idx_q[T][M];
      assign stage_k  = tap_idx_q[T] & K_MASK;
      assign sw_d[gi] = tap_valid_q[T] ? stage_sw : sw_q[gi];
      assign tw_d[gi*TW_W +: TW_W] = !tap_valid_q[T] ? tw_q[gi*TW_W +: TW_W] :
                                     stage_sw ? TW_W'(stage_k << gi) : '0;
    end
  endgenerate

  always_comb begin
    out_valid   = tap_valid_q[LAST];
    out_sof     = tap_valid_q[LAST] & tap_sof_q[LAST];
    out_eof     = tap_valid_q[LAST] & (tap_idx_q[LAST] == IDX_LAST);
    busy        = (state_q == RUN) | (|tap_valid_q);
    frame_cnt_d = frame_cnt_q + FCNT_W'(out_eof);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
      sw_q        <= '0;
      tw_q        <= '0;
      tap_valid_q <= '0;
      tap_sof_q   <= '0;
      for (int t = 0; t < DEPTH; t++) begin
        tap_idx_q[t] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sync_err_q  <= sync_err_d;
      frame_cnt_q <= frame_cnt_d;
      sw_q        <= sw_d;
      tw_q        <= tw_d;
      tap_valid_q <= tap_valid_d;
      tap_sof_q   <= tap_sof_d;
      for (int t = 0; t < DEPTH; t++) begin
        tap_idx_q[t] <= tap_idx_d[t];
      end
    end
  end

  assign sw        = sw_q;
  assign tw_addr   = tw_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
